bcd_down_counter: RTL and testbench

BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_down.sv | 31 +++
 rtl/bcd_down_counter.sv | 101 ++++++++++
 tb/tb_bcd_down_counter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and sanitising helpers for the BCD down counter.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // True when a raw nibble is not a legal decimal digit (A..F)
  function automatic logic bcd_invalid(input bcd_digit_t d);
    return (d > BCD_MAX);
  endfunction

  // Force an arbitrary nibble into the legal 0..9 range, saturating at 9
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return bcd_invalid(d) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One decade of the BCD down counter: holds a digit, loads it, and decrements on borrow.
// borrow_out is a pure function of borrow_in and the held digit, so a chain fed with a
// constant 1 reports "every digit is zero" at its far end.
module bcd_digit_down
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       borrow_in,
  output logic       borrow_out,
  output bcd_digit_t digit
);

  // Propagate a borrow past this digit only when it is already at zero
  assign borrow_out = borrow_in & (digit == BCD_ZERO);

  // Digit register: reset, then load, then decimal decrement with 0 -> 9 wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= load_digit;
    end else if (en && borrow_in) begin
      digit <= (digit == BCD_ZERO) ? BCD_MAX : bcd_digit_t'(digit - 4'd1);
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Cascaded NDIGITS-decade BCD down counter with parallel load, zero flag, done pulse
// and load-error pulse. Define BCD_DOWN_COUNTER_AUTORELOAD_EN to restart the count
// from the last loaded value when it is exhausted; otherwise it holds at zero.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [BCD_W*NDIGITS-1:0] load_val,
  input  logic                     en,
  output logic [BCD_W*NDIGITS-1:0] out,
  output logic                     zero,
  output logic                     done,
  output logic                     load_err
);

  localparam int unsigned W = BCD_W * NDIGITS;

  logic [W-1:0]     clean_val;
  logic             any_bad;
  logic [W-1:0]     src_val;
  logic             digit_load;
  logic             dec;
  logic [NDIGITS:0] borrow;
  bcd_digit_t       digits [NDIGITS];

  // Clamp every incoming digit to 9 and note whether any needed clamping
  always_comb begin
    clean_val = '0;
    any_bad   = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      clean_val[BCD_W*i +: BCD_W] = bcd_clamp(load_val[BCD_W*i +: BCD_W]);
      any_bad = any_bad | bcd_invalid(load_val[BCD_W*i +: BCD_W]);
    end
  end

  // The borrow chain's far end is high exactly when every digit reads zero
  assign borrow[0] = 1'b1;
  assign zero      = borrow[NDIGITS];

  // Decrement only when counting is requested, not overridden by load, and not at zero
  assign dec = en & ~load & ~zero;

`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
  logic [W-1:0] reload_q;
  logic         reload_now;

  // Capture every sanitised load so an exhausted count can restart from it
  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= clean_val;
    end
  end

  assign reload_now = en & ~load & zero;
  assign digit_load = load | reload_now;
  assign src_val    = load ? clean_val : reload_q;
`else
  assign digit_load = load;
  assign src_val    = clean_val;
`endif

  // One decade per digit, least significant first, linked through the borrow chain
  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    bcd_digit_down u_digit (
      .clk        (clk),
      .reset      (reset),
      .en         (dec),
      .load       (digit_load),
      .load_digit (src_val[BCD_W*g +: BCD_W]),
      .borrow_in  (borrow[g]),
      .borrow_out (borrow[g+1]),
      .digit      (digits[g])
    );
  end

  // Pack the digit registers onto the output bus, digit 0 in the low nibble
  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      out[BCD_W*i +: BCD_W] = digits[i];
    end
  end

  // Status pulses: done on the 1 -> 0 decrement, load_err after a clamped load
  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= dec & (out == W'(1));
      load_err <= load & any_bad;
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter (NDIGITS=4): directed scenarios followed by
// random traffic, all compared against an integer-arithmetic reference model.
// Honours BCD_DOWN_COUNTER_AUTORELOAD_EN the same way the design does.
module tb_bcd_down_counter;

  localparam int N = 4;

  logic          clk;
  logic          reset;
  logic          load;
  logic [4*N-1:0] load_val;
  logic          en;
  logic [4*N-1:0] out;
  logic          zero;
  logic          done;
  logic          load_err;

  int    tests_run = 0;
  int    failed    = 0;
  string phase     = "init";

  // Reference model state: the count as a plain integer
  int   m_val    = 0;
  int   m_reload = 0;
  logic m_done   = 1'b0;
  logic m_lerr   = 1'b0;

  bcd_down_counter #(.NDIGITS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .out      (out),
    .zero     (zero),
    .done     (done),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*N-1:0] int_to_bcd(input int x);
    logic [4*N-1:0] r;
    int v;
    r = '0;
    v = x;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad_digit(input logic [4*N-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (v[4*i +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  // Behavioural next-state: decimal value arithmetic, no digit-level borrow logic
  task automatic model(input logic r, input logic l, input logic [4*N-1:0] lv, input logic e);
    int cv;
    int d;
    logic bad;
    m_done = 1'b0;
    m_lerr = 1'b0;
    if (r) begin
      m_val    = 0;
      m_reload = 0;
    end else if (l) begin
      cv  = 0;
      bad = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
        d = int'(lv[4*i +: 4]);
        if (d > 9) begin
          bad = 1'b1;
          d   = 9;
        end
        cv = cv * 10 + d;
      end
      m_val    = cv;
      m_reload = cv;
      m_lerr   = bad;
    end else if (e) begin
      if (m_val > 0) begin
        m_done = (m_val == 1);
        m_val  = m_val - 1;
      end else begin
`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
        m_val = m_reload;
`else
        m_val = 0;
`endif
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs after the edge
  task automatic cyc(input logic r, input logic l, input logic [4*N-1:0] lv, input logic e);
    reset    = r;
    load     = l;
    load_val = lv;
    en       = e;
    model(r, l, lv, e);
    @(posedge clk);
    #1;
    check("out", 32'(out), 32'(int_to_bcd(m_val)));
    check("zero", 32'(zero), 32'(m_val == 0));
    check("done", 32'(done), 32'(m_done));
    check("load_err", 32'(load_err), 32'(m_lerr));
    check("bcd_legal", 32'(has_bad_digit(out)), 32'd0);
  endtask

  initial begin
    logic [4*N-1:0] rv;

    phase = "reset";
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 16'h1234, 1'b1);
    check("zero_after_reset", 32'(zero), 32'd1);
    check("out_after_reset", 32'(out), 32'h0);

    phase = "count_0103";
    cyc(1'b0, 1'b1, 16'h0103, 1'b0);
    check("loaded", 32'(out), 32'h0103);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("c1", 32'(out), 32'h0102);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("c2", 32'(out), 32'h0101);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("c3", 32'(out), 32'h0100);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("c4_borrow", 32'(out), 32'h0099);

    phase = "count_to_zero";
    cyc(1'b0, 1'b1, 16'h0002, 1'b1);
    check("load_over_en", 32'(out), 32'h0002);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("at_one", 32'(out), 32'h0001);
    check("no_done_yet", 32'(done), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("at_zero", 32'(out), 32'h0000);
    check("done_pulse", 32'(done), 32'd1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("done_cleared", 32'(done), 32'd0);
`ifdef BCD_DOWN_COUNTER_AUTORELOAD_EN
    check("reloaded", 32'(out), 32'h0002);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("reload_1", 32'(out), 32'h0001);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("reload_0", 32'(out), 32'h0000);
    check("reload_done", 32'(done), 32'd1);
`else
    check("hold_zero", 32'(out), 32'h0000);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("hold_zero2", 32'(out), 32'h0000);
    check("no_wrap_done", 32'(done), 32'd0);
`endif

    phase = "clamp";
    cyc(1'b0, 1'b1, 16'h1A3F, 1'b0);
    check("clamped", 32'(out), 32'h1939);
    check("err_pulse", 32'(load_err), 32'd1);
    check("no_done", 32'(done), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    check("err_cleared", 32'(load_err), 32'd0);

    phase = "load_and_reset_mid";
    cyc(1'b0, 1'b1, 16'h0501, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("at_0500", 32'(out), 32'h0500);
    cyc(1'b0, 1'b1, 16'h0042, 1'b1);
    check("reload_42", 32'(out), 32'h0042);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    check("at_0039", 32'(out), 32'h0039);
    cyc(1'b1, 1'b0, '0, 1'b1);
    check("reset_out", 32'(out), 32'h0000);
    check("reset_zero", 32'(zero), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("stay_after_reset", 32'(out), 32'h0000);

    phase = "hold_0733";
    cyc(1'b0, 1'b1, 16'h0733, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 16'hFFFF, 1'b0);
      check("held", 32'(out), 32'h0733);
    end

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1, 2) == 1) rv = 16'($urandom);
      else rv = int_to_bcd(int'($urandom_range(0, 15)));
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10), rv,
          ($urandom_range(0, 99) < 80));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
